// File: rtl/sdram_rd_ctrl_pkg.sv
// Shared types and defaults for the SDRAM read-back engine.
package sdram_rd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_READ   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int FIFO_UP_DEF = 768;
  localparam int FIFO_DN_DEF = 512;

endpackage

// File: rtl/sdram_rd_ctrl_if.sv
// Control, SDRAM read and FIFO write signals of the read-back engine.
interface sdram_rd_ctrl_if #(
  parameter int DW        = 16,
  parameter int AW        = 32,
  parameter int HDR_WORDS = 4,
  parameter int CW        = 10
);
  logic                    sys_en;
  logic                    read_start;
  logic                    lpb_mode;
  logic [AW-1:0]           saddr;
  logic [AW-1:0]           last_addr;
  logic [31:0]             rd_len;
  logic [HDR_WORDS*DW-1:0] hdr_data;
  logic                    rd_req;
  logic [AW-1:0]           rd_addr;
  logic                    rd_valid;
  logic                    rd_rdy;
  logic [DW-1:0]           rd_data;
  logic [CW-1:0]           fifo_wcnt;
  logic                    fifo_full;
  logic                    fifo_wr;
  logic [DW-1:0]           fifo_din;
  logic                    busy;
  logic                    done;
  logic                    err_ovf;

  // master: the read engine; slave: SDRAM controller, FIFO and system control
  modport master (
    input  sys_en, read_start, lpb_mode, saddr, last_addr, rd_len, hdr_data,
           rd_valid, rd_rdy, rd_data, fifo_wcnt, fifo_full,
    output rd_req, rd_addr, fifo_wr, fifo_din, busy, done, err_ovf
  );

  modport slave (
    output sys_en, read_start, lpb_mode, saddr, last_addr, rd_len, hdr_data,
           rd_valid, rd_rdy, rd_data, fifo_wcnt, fifo_full,
    input  rd_req, rd_addr, fifo_wr, fifo_din, busy, done, err_ovf
  );
endinterface

// File: rtl/sdram_rd_hdr_seq.sv
// Header word sequencer: index counter that selects one DW-bit word of hdr_data.
module sdram_rd_hdr_seq #(
  parameter int DW        = 16,
  parameter int HDR_WORDS = 4
) (
  input  logic                    sdram_clk,
  input  logic                    sdram_rst,
  input  logic                    start_i,
  input  logic                    advance_i,
  input  logic [HDR_WORDS*DW-1:0] hdr_data_i,
  output logic                    last_o,
  output logic [DW-1:0]           word_o
);
  localparam int IW = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;

  logic [IW-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (start_i)        idx_d = '0;
    else if (advance_i) idx_d = last_o ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) idx_q <= '0;
    else           idx_q <= idx_d;
  end

  assign last_o = (idx_q == IW'(HDR_WORDS - 1));
  assign word_o = hdr_data_i[int'(idx_q)*DW +: DW];
endmodule

// File: rtl/sdram_rd_ctrl.sv
// SDRAM read-back engine: header then bounded/unbounded read stream into the read FIFO.
// state  | meaning
// IDLE   | waiting for read_start
// HEADER | writing header words to the FIFO
// READ   | issuing requests, forwarding data
// DRAIN  | all requests accepted, waiting for the remaining data
// DONE   | bounded read finished, done held
module sdram_rd_ctrl
  import sdram_rd_ctrl_pkg::*;
#(
  parameter int DW        = 16,
  parameter int AW        = 32,
  parameter int ADDR_STEP = 4,
  parameter int HDR_WORDS = 4,
  parameter int CW        = 10,
  parameter int FIFO_UP   = FIFO_UP_DEF,
  parameter int FIFO_DN   = FIFO_DN_DEF
) (
  input logic             sdram_clk,
  input logic             sdram_rst,
  sdram_rd_ctrl_if.master bus_if
);
  localparam logic [CW-1:0] UP_C   = CW'(FIFO_UP);
  localparam logic [CW-1:0] DN_C   = CW'(FIFO_DN);
  localparam logic [AW-1:0] STEP_C = AW'(ADDR_STEP);

  state_e        state_q, state_d;
  logic [2:0]    en_sync_q;
  logic          abort;
  logic          rd_req_q, rd_req_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          done_q, done_d;
  logic          err_ovf_q, err_ovf_d;
  logic          bounded_q, bounded_d;
  logic [31:0]   req_left_q, req_left_d;
  logic [31:0]   data_left_q, data_left_d;
  logic          hdr_start, hdr_adv, hdr_last;
  logic [DW-1:0] hdr_word;
  logic          fifo_wr;
  logic [DW-1:0] fifo_din;

  sdram_rd_hdr_seq #(.DW(DW), .HDR_WORDS(HDR_WORDS)) u_hdr_seq (
    .sdram_clk  (sdram_clk),
    .sdram_rst  (sdram_rst),
    .start_i    (hdr_start),
    .advance_i  (hdr_adv),
    .hdr_data_i (bus_if.hdr_data),
    .last_o     (hdr_last),
    .word_o     (hdr_word)
  );

  // en_sync_q[0..2] = s0..s2; abort on the synchronised falling edge
  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) en_sync_q <= '0;
    else           en_sync_q <= {en_sync_q[1:0], bus_if.sys_en};
  end
  assign abort = en_sync_q[2] & ~en_sync_q[1];

  always_comb begin
    state_d     = state_q;
    rd_req_d    = rd_req_q;
    rd_addr_d   = rd_addr_q;
    done_d      = done_q;
    err_ovf_d   = err_ovf_q;
    bounded_d   = bounded_q;
    req_left_d  = req_left_q;
    data_left_d = data_left_q;
    hdr_start   = 1'b0;
    hdr_adv     = 1'b0;
    fifo_wr     = 1'b0;
    fifo_din    = bus_if.rd_data;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus_if.read_start) begin
          rd_addr_d   = bus_if.saddr;
          req_left_d  = bus_if.rd_len;
          data_left_d = bus_if.rd_len;
          bounded_d   = (bus_if.rd_len != 32'd0);
          done_d      = 1'b0;
          err_ovf_d   = 1'b0;
          hdr_start   = 1'b1;
          if (bus_if.lpb_mode) begin
            state_d  = ST_READ;
            rd_req_d = 1'b1;
          end else begin
            state_d  = ST_HEADER;
          end
        end
      end
      ST_HEADER: begin
        fifo_din = hdr_word;
        if (!bus_if.fifo_full) begin
          fifo_wr = 1'b1;
          hdr_adv = 1'b1;
          if (hdr_last) begin
            state_d  = ST_READ;
            rd_req_d = 1'b1;
          end
        end
      end
      ST_READ, ST_DRAIN: begin
        fifo_wr = bus_if.rd_rdy;
        if (bus_if.rd_rdy) begin
          if (bus_if.fifo_full) err_ovf_d = 1'b1;
          if (bounded_q && data_left_q != 32'd0) data_left_d = data_left_q - 32'd1;
        end
        if (state_q == ST_READ) begin
          if (bus_if.fifo_wcnt >= UP_C)      rd_req_d = 1'b0;
          else if (bus_if.fifo_wcnt <= DN_C) rd_req_d = 1'b1;
        end
        // the final accepted request overrides the fill-level hysteresis
        if (bus_if.rd_valid) begin
          rd_addr_d = (rd_addr_q == bus_if.last_addr) ? '0 : rd_addr_q + STEP_C;
          if (bounded_q && req_left_q != 32'd0) begin
            req_left_d = req_left_q - 32'd1;
            if (req_left_q == 32'd1 && state_q == ST_READ) begin
              rd_req_d = 1'b0;
              state_d  = ST_DRAIN;
            end
          end
        end
        if (state_q == ST_DRAIN && data_left_d == 32'd0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d     = ST_IDLE;
      rd_req_d    = 1'b0;
      done_d      = 1'b0;
      rd_addr_d   = rd_addr_q;
      err_ovf_d   = err_ovf_q;
      bounded_d   = bounded_q;
      req_left_d  = req_left_q;
      data_left_d = data_left_q;
      hdr_start   = 1'b0;
      hdr_adv     = 1'b0;
      fifo_wr     = 1'b0;
    end
  end

  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      state_q     <= ST_IDLE;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      done_q      <= 1'b0;
      err_ovf_q   <= 1'b0;
      bounded_q   <= 1'b0;
      req_left_q  <= '0;
      data_left_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      done_q      <= done_d;
      err_ovf_q   <= err_ovf_d;
      bounded_q   <= bounded_d;
      req_left_q  <= req_left_d;
      data_left_q <= data_left_d;
    end
  end

  assign bus_if.rd_req   = rd_req_q;
  assign bus_if.rd_addr  = rd_addr_q;
  assign bus_if.fifo_wr  = fifo_wr;
  assign bus_if.fifo_din = fifo_din;
  assign bus_if.done     = done_q;
  assign bus_if.err_ovf  = err_ovf_q;
  assign bus_if.busy     = (state_q == ST_HEADER) || (state_q == ST_READ) ||
                           (state_q == ST_DRAIN);
endmodule

// File: tb/tb_sdram_rd_ctrl.sv
// Directed bench for sdram_rd_ctrl: vector table for header + bounded read, hand sequences for the rest.
module tb_sdram_rd_ctrl;
  logic sdram_clk = 1'b0;
  logic sdram_rst = 1'b1;
  int   checks    = 0;
  int   failures  = 0;

  always #5 sdram_clk = ~sdram_clk;

  sdram_rd_ctrl_if #(.DW(16), .AW(32), .HDR_WORDS(4), .CW(10)) bus_if ();

  sdram_rd_ctrl #(
    .DW(16), .AW(32), .ADDR_STEP(4), .HDR_WORDS(4), .CW(10),
    .FIFO_UP(768), .FIFO_DN(512)
  ) dut (
    .sdram_clk (sdram_clk),
    .sdram_rst (sdram_rst),
    .bus_if    (bus_if)
  );

  typedef struct {
    logic        ff;
    logic        vld;
    logic        rdy;
    logic [15:0] data;
    logic        req;
    logic [31:0] addr;
    logic        wr;
    logic [15:0] din;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl [0:11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge sdram_clk);
    @(negedge sdram_clk);
  endtask

  task automatic start(input logic lpb, input logic [31:0] sa, input logic [31:0] la,
                       input logic [31:0] len);
    bus_if.lpb_mode   = lpb;
    bus_if.saddr      = sa;
    bus_if.last_addr  = la;
    bus_if.rd_len     = len;
    bus_if.read_start = 1'b1;
    step();
    bus_if.read_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc [6];
    logic ex [6];
    int n;

    bus_if.sys_en     = 1'b1;
    bus_if.read_start = 1'b0;
    bus_if.lpb_mode   = 1'b0;
    bus_if.saddr      = '0;
    bus_if.last_addr  = 32'h3FC;
    bus_if.rd_len     = '0;
    bus_if.hdr_data   = 64'h4444_3333_2222_1111;
    bus_if.rd_valid   = 1'b0;
    bus_if.rd_rdy     = 1'b0;
    bus_if.rd_data    = '0;
    bus_if.fifo_wcnt  = '0;
    bus_if.fifo_full  = 1'b0;

    //          ff   vld  rdy  data      req  addr     wr   din       busy done
    tbl[0]  = '{1'b0,1'b0,1'b0,16'h0000, 1'b0,32'h100, 1'b1,16'h1111, 1'b1,1'b0};
    tbl[1]  = '{1'b1,1'b0,1'b0,16'h0000, 1'b0,32'h100, 1'b0,16'h0000, 1'b1,1'b0};
    tbl[2]  = '{1'b1,1'b0,1'b0,16'h0000, 1'b0,32'h100, 1'b0,16'h0000, 1'b1,1'b0};
    tbl[3]  = '{1'b1,1'b0,1'b0,16'h0000, 1'b0,32'h100, 1'b0,16'h0000, 1'b1,1'b0};
    tbl[4]  = '{1'b0,1'b0,1'b0,16'h0000, 1'b0,32'h100, 1'b1,16'h2222, 1'b1,1'b0};
    tbl[5]  = '{1'b0,1'b0,1'b1,16'hDEAD, 1'b0,32'h100, 1'b1,16'h3333, 1'b1,1'b0};
    tbl[6]  = '{1'b0,1'b0,1'b0,16'h0000, 1'b0,32'h100, 1'b1,16'h4444, 1'b1,1'b0};
    tbl[7]  = '{1'b0,1'b1,1'b0,16'h0000, 1'b1,32'h100, 1'b0,16'h0000, 1'b1,1'b0};
    tbl[8]  = '{1'b0,1'b1,1'b1,16'hA001, 1'b1,32'h104, 1'b1,16'hA001, 1'b1,1'b0};
    tbl[9]  = '{1'b0,1'b1,1'b1,16'hA002, 1'b1,32'h108, 1'b1,16'hA002, 1'b1,1'b0};
    tbl[10] = '{1'b0,1'b0,1'b1,16'hA003, 1'b0,32'h10C, 1'b1,16'hA003, 1'b1,1'b0};
    tbl[11] = '{1'b0,1'b0,1'b0,16'h0000, 1'b0,32'h10C, 1'b0,16'h0000, 1'b0,1'b1};

    repeat (3) @(negedge sdram_clk);
    sdram_rst = 1'b0;
    #1;
    chk("rst_rd_req",  32'(bus_if.rd_req),  32'd0);
    chk("rst_rd_addr", bus_if.rd_addr,      32'd0);
    chk("rst_done",    32'(bus_if.done),    32'd0);
    chk("rst_err_ovf", 32'(bus_if.err_ovf), 32'd0);
    chk("rst_busy",    32'(bus_if.busy),    32'd0);
    chk("rst_fifo_wr", 32'(bus_if.fifo_wr), 32'd0);
    repeat (4) step();

    // header with backpressure, then bounded read of 3
    start(1'b0, 32'h100, 32'h3FC, 32'd3);
    for (int i = 0; i <= 11; i++) begin
      bus_if.fifo_full = tbl[i].ff;
      bus_if.rd_valid  = tbl[i].vld;
      bus_if.rd_rdy    = tbl[i].rdy;
      bus_if.rd_data   = tbl[i].data;
      #1;
      chk($sformatf("v%0d_rd_req", i),  32'(bus_if.rd_req),  32'(tbl[i].req));
      chk($sformatf("v%0d_rd_addr", i), bus_if.rd_addr,      tbl[i].addr);
      chk($sformatf("v%0d_fifo_wr", i), 32'(bus_if.fifo_wr), 32'(tbl[i].wr));
      if (tbl[i].wr)
        chk($sformatf("v%0d_fifo_din", i), 32'(bus_if.fifo_din), 32'(tbl[i].din));
      chk($sformatf("v%0d_busy", i),    32'(bus_if.busy),    32'(tbl[i].busy));
      chk($sformatf("v%0d_done", i),    32'(bus_if.done),    32'(tbl[i].done));
      chk($sformatf("v%0d_err_ovf", i), 32'(bus_if.err_ovf), 32'd0);
      step();
    end
    bus_if.rd_valid = 1'b0;
    bus_if.rd_rdy   = 1'b0;
    chk("done_held", 32'(bus_if.done), 32'd1);

    // unbounded loopback with address wrap
    start(1'b1, 32'h3FC, 32'h3FC, 32'd0);
    chk("wrap_done_clr", 32'(bus_if.done),   32'd0);
    chk("wrap_req",      32'(bus_if.rd_req), 32'd1);
    chk("wrap_a0",       bus_if.rd_addr,     32'h3FC);
    bus_if.rd_valid = 1'b1;
    step();
    chk("wrap_a1", bus_if.rd_addr, 32'h000);
    step();
    chk("wrap_a2", bus_if.rd_addr, 32'h004);
    bus_if.rd_valid = 1'b0;
    bus_if.saddr    = 32'h500;
    bus_if.read_start = 1'b1;
    step();
    bus_if.read_start = 1'b0;
    chk("start_ignored_addr", bus_if.rd_addr,   32'h004);
    chk("start_ignored_busy", 32'(bus_if.busy), 32'd1);
    chk("wrap_done_low",      32'(bus_if.done), 32'd0);

    // rd_req hysteresis
    wc = '{700, 767, 768, 700, 513, 512};
    ex = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      bus_if.fifo_wcnt = 10'(wc[i]);
      step();
      chk($sformatf("hyst_wcnt%0d", wc[i]), 32'(bus_if.rd_req), 32'(ex[i]));
    end
    bus_if.fifo_wcnt = '0;

    // overflow: data still presented, error sticky
    bus_if.fifo_full = 1'b1;
    bus_if.rd_rdy    = 1'b1;
    bus_if.rd_data   = 16'hBEEF;
    #1;
    chk("ovf_wr",  32'(bus_if.fifo_wr),  32'd1);
    chk("ovf_din", 32'(bus_if.fifo_din), 32'hBEEF);
    step();
    bus_if.fifo_full = 1'b0;
    bus_if.rd_rdy    = 1'b0;
    chk("ovf_err", 32'(bus_if.err_ovf), 32'd1);

    // abort via sys_en falling edge
    bus_if.sys_en = 1'b0;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (!bus_if.busy && !bus_if.rd_req) begin
        n = i;
        break;
      end
    end
    chk("abort_seen",    32'(n != 0),         32'd1);
    chk("abort_latency", 32'(n <= 4),         32'd1);
    bus_if.rd_rdy = 1'b1;
    #1;
    chk("abort_drop_wr", 32'(bus_if.fifo_wr), 32'd0);
    chk("abort_done",    32'(bus_if.done),    32'd0);
    bus_if.rd_rdy = 1'b0;
    bus_if.sys_en = 1'b1;
    repeat (5) step();

    // single-request bounded read with late data; err_ovf cleared by start
    start(1'b1, 32'h20, 32'h3FC, 32'd1);
    chk("s1_err_clr", 32'(bus_if.err_ovf), 32'd0);
    chk("s1_addr",    bus_if.rd_addr,      32'h20);
    chk("s1_req",     32'(bus_if.rd_req),  32'd1);
    bus_if.rd_valid = 1'b1;
    step();
    bus_if.rd_valid = 1'b0;
    chk("s1_req_off", 32'(bus_if.rd_req), 32'd0);
    chk("s1_addr2",   bus_if.rd_addr,     32'h24);
    step();
    chk("s1_wait_busy", 32'(bus_if.busy), 32'd1);
    chk("s1_wait_done", 32'(bus_if.done), 32'd0);
    bus_if.rd_rdy  = 1'b1;
    bus_if.rd_data = 16'h55AA;
    #1;
    chk("s1_wr",  32'(bus_if.fifo_wr),  32'd1);
    chk("s1_din", 32'(bus_if.fifo_din), 32'h55AA);
    step();
    bus_if.rd_rdy = 1'b0;
    chk("s1_done", 32'(bus_if.done), 32'd1);
    chk("s1_busy", 32'(bus_if.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
